crc_seq: RTL

CRC_SEQ -- requirements
Module: crc_seq

---
 rtl/crc_seq_pkg.sv | 29 ++
 rtl/crc_seq_bit_cnt.sv | 33 +++
 rtl/crc_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/crc_seq_pkg.sv
// Shared constants for the CRC frame sequencer: state encoding, byte width,
// default CRC length and the seed value the external engine loads on eng_seed.
package crc_seq_pkg;

    // Width of one upstream byte; bytes are serialized LSB first.
    localparam int BYTE_W = 8;

    // Default number of CRC output cycles.
    localparam int CRC_W_DEF = 8;

    // Seed the external CRC engine loads when eng_seed pulses.
    localparam logic [CRC_W_DEF-1:0] CRC_SEED = 8'hFF;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SEED  = 3'd1;
    localparam state_t ST_FILL  = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_CRC   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // True in the states where the shared bit/CRC counter runs.
    function automatic logic is_counting(input state_t s);
        return (s == ST_SHIFT) || (s == ST_CRC);
    endfunction

endpackage

// File: rtl/crc_seq_bit_cnt.sv
// Loadable up-counter with a terminal-count flag. One instance counts the
// eight bit times of a byte in SHIFT and the CRC_W output cycles in CRC.
module crc_bit_cnt
    import crc_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Count register: load has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal count only reported while counting, so it is quiet in idle states.
    assign tc = en && (count == term);

endmodule

// File: rtl/crc_seq.sv
// CRC frame sequencer: seeds an external serial CRC engine, accepts bytes
// through a valid/ready handshake with a one-entry holding register so that
// consecutive bytes stream without gaps, then clocks out CRC_W CRC bits.
// Every output is decoded from state, counter and internal registers only.
module crc_seq
    import crc_seq_pkg::*;
#(
    parameter int CRC_W = CRC_W_DEF,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frm_start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              eng_seed,
    output logic              eng_active,
    output logic              eng_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            nxt_state;

    logic [BYTE_W-1:0] shreg;
    logic              cur_last;

    logic [BYTE_W-1:0] hold_data;
    logic              hold_last;
    logic              hold_full;
    logic              last_seen;

    logic              xfer;
    logic              cnt_en;
    logic              cnt_load;
    logic              cnt_tc;
    logic [CNT_W-1:0]  cnt_term;

    logic              in_shift;
    logic              reload;
    logic              underrun;

    assign in_shift = (state == ST_SHIFT);
    assign xfer     = byte_valid && byte_ready;

    // Byte 7 done and the next byte is already waiting: swap it in seamlessly.
    assign reload   = in_shift && cnt_tc && !cur_last && hold_full;

    // Byte 7 done, frame not finished and nothing waiting: abort.
    assign underrun = in_shift && cnt_tc && !cur_last && !hold_full;

    // The counter runs in SHIFT and CRC and is cleared whenever it is idle or
    // has just hit its terminal count, so every SHIFT/CRC phase starts at 0.
    assign cnt_en   = is_counting(state);
    assign cnt_load = !cnt_en || cnt_tc;
    assign cnt_term = (state == ST_CRC) ? CNT_W'(CRC_W - 1) : CNT_W'(BYTE_W - 1);

    crc_bit_cnt #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .term     (cnt_term),
        .tc       (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state decode.
    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: begin
                if (frm_start) begin
                    nxt_state = ST_SEED;
                end
            end
            ST_SEED: begin
                nxt_state = ST_FILL;
            end
            ST_FILL: begin
                if (xfer) begin
                    nxt_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc) begin
                    if (cur_last) begin
                        nxt_state = ST_CRC;
                    end else if (!hold_full) begin
                        nxt_state = ST_IDLE;
                    end
                end
            end
            ST_CRC: begin
                if (cnt_tc) begin
                    nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // Shift register and current-byte last flag: load from the bus in FILL,
    // from the holding register at a byte boundary, otherwise shift right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            cur_last <= 1'b0;
        end else if ((state == ST_FILL) && xfer) begin
            shreg    <= byte_data;
            cur_last <= byte_last;
        end else if (reload) begin
            shreg    <= hold_data;
            cur_last <= hold_last;
        end else if (in_shift) begin
            shreg    <= {1'b0, shreg[BYTE_W-1:1]};
        end
    end

    // Holding register and last_seen: a byte accepted during SHIFT waits here
    // until the current byte finishes. Both flags drop whenever a frame ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            last_seen <= 1'b0;
        end else if ((state == ST_IDLE) || (state == ST_DONE) || underrun) begin
            hold_full <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (in_shift && xfer) begin
                hold_data <= byte_data;
                hold_last <= byte_last;
                hold_full <= 1'b1;
            end else if (reload) begin
                hold_full <= 1'b0;
            end
            if (xfer && byte_last) begin
                last_seen <= 1'b1;
            end
        end
    end

    // Handshake: always ready in FILL; in SHIFT only while the holding slot is
    // free, the frame's last byte has not yet been taken, and this is not the
    // bit-7 cycle (where an empty slot means the frame is being aborted).
    always_comb begin
        byte_ready = 1'b0;
        case (state)
            ST_FILL:  byte_ready = 1'b1;
            ST_SHIFT: byte_ready = !hold_full && !last_seen && !cnt_tc;
            default:  byte_ready = 1'b0;
        endcase
    end

    // Engine-side and status outputs decoded from state.
    always_comb begin
        eng_seed   = (state == ST_SEED);
        eng_active = in_shift;
        eng_bit    = in_shift && shreg[0];
        out_valid  = (state == ST_CRC);
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        err        = underrun;
    end

endmodule
